// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for an 8-way, 8-bit switch-bank mux.
// One requester owns the mux path at a time for at most DWELL cycles. The
// owner's bank is registered onto led. All outputs come straight from flops.
module mux_rr_arbiter #(
  parameter int unsigned DWELL = 4  // cycles a grant may be held, 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] sw0,
  input  logic [7:0] sw1,
  input  logic [7:0] sw2,
  input  logic [7:0] sw3,
  input  logic [7:0] sw4,
  input  logic [7:0] sw5,
  input  logic [7:0] sw6,
  input  logic [7:0] sw7,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic [7:0] led,
  output logic       led_valid
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [7:0] DwellInit = 8'(DWELL - 1);

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [7:0] cnt_q;
  logic [7:0] gnt_q;
  logic [2:0] sel_q;
  logic [7:0] led_q;
  logic       led_valid_q;

  logic [7:0]  sw_bank [8];
  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  offset;
  logic [2:0]  winner;
  logic        any_req;
  logic        release_grant;
  logic        take_grant;

  assign sw_bank[0] = sw0;
  assign sw_bank[1] = sw1;
  assign sw_bank[2] = sw2;
  assign sw_bank[3] = sw3;
  assign sw_bank[4] = sw4;
  assign sw_bank[5] = sw5;
  assign sw_bank[6] = sw6;
  assign sw_bank[7] = sw7;

  // Rotate req so bit 0 is the ptr position, then take the lowest set bit.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[7:0];
    offset  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = 3'(i);
      end
    end
    // 3-bit add wraps mod 8 naturally.
    winner  = ptr_q + offset;
    any_req = |req;
  end

  // The current grant ends when its owner lets go or the dwell runs out.
  always_comb begin
    release_grant = (state_q == StGrant) && (!req[sel_q] || (cnt_q == 8'd0));
    take_grant    = any_req && ((state_q == StIdle) || release_grant);
  end

  // State, pointer, dwell counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 3'd0;
      cnt_q       <= 8'd0;
      gnt_q       <= 8'd0;
      sel_q       <= 3'd0;
      led_q       <= 8'd0;
      led_valid_q <= 1'b0;
    end else if (take_grant) begin
      // New grant (from idle or back-to-back); ptr moves past the winner so
      // it becomes lowest priority next time.
      state_q     <= StGrant;
      ptr_q       <= winner + 3'd1;
      cnt_q       <= DwellInit;
      gnt_q       <= 8'd1 << winner;
      sel_q       <= winner;
      led_q       <= sw_bank[winner];
      led_valid_q <= 1'b1;
    end else if (release_grant || (state_q == StIdle)) begin
      // Nobody is asking: drop the grant, sel/led keep their last values.
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      gnt_q       <= 8'd0;
      led_valid_q <= 1'b0;
    end else begin
      // Owner keeps the path; track its bank and burn one dwell cycle.
      if (cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      led_q <= sw_bank[sel_q];
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign led       = led_q;
  assign led_valid = led_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and random stimulus for mux_rr_arbiter with a scoreboard of
// expected outputs built from an independent behavioural model.
module tb_mux_rr_arbiter;

  localparam int Dwell = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] bsw [8];
  logic [7:0] gnt;
  logic [2:0] sel;
  logic [7:0] led;
  logic       led_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic [7:0] led;
    logic       valid;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  bit         m_busy;
  int         m_owner;
  int         m_ptr;
  int         m_held;
  logic [2:0] m_sel;
  logic [7:0] m_led;

  mux_rr_arbiter #(.DWELL(Dwell)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .sw0      (bsw[0]),
    .sw1      (bsw[1]),
    .sw2      (bsw[2]),
    .sw3      (bsw[3]),
    .sw4      (bsw[4]),
    .sw5      (bsw[5]),
    .sw6      (bsw[6]),
    .sw7      (bsw[7]),
    .gnt      (gnt),
    .sel      (sel),
    .led      (led),
    .led_valid(led_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 3'd0;
    m_led   = 8'h00;
  endtask

  // Predict the outputs after the next edge for request vector r.
  task automatic model_edge(input logic [7:0] r);
    bit   rel;
    bit   found;
    int   w;
    exp_t e;
    rel   = !m_busy || !r[m_owner] || (m_held >= Dwell - 1);
    found = 1'b0;
    w     = 0;
    if (rel) begin
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (!found && r[idx]) begin
          found = 1'b1;
          w     = idx;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_ptr   = (w + 1) % 8;
        m_held  = 0;
        m_sel   = 3'(w);
        m_led   = bsw[w];
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_held++;
      m_led = bsw[m_owner];
    end
    e.gnt   = m_busy ? (8'd1 << m_owner) : 8'd0;
    e.sel   = m_sel;
    e.led   = m_led;
    e.valid = m_busy;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r);
    exp_t e;
    req = r;
    model_edge(r);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("sel", 32'(sel), 32'(e.sel));
      chk("led", 32'(led), 32'(e.led));
      chk("led_valid", 32'(led_valid), 32'(e.valid));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    for (int i = 0; i < 8; i++) bsw[i] = 8'h00;
    model_reset();
    #1;
    chk("por_gnt", 32'(gnt), 32'h0);
    chk("por_valid", 32'(led_valid), 32'h0);
    chk("por_led", 32'(led), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester 3: granted next edge, re-granted without a gap.
    bsw[3] = 8'hA5;
    step(8'h08);
    chk("single_gnt", 32'(gnt), 32'h08);
    chk("single_sel", 32'(sel), 32'd3);
    chk("single_led", 32'(led), 32'hA5);
    for (int i = 0; i < 5; i++) begin
      step(8'h08);
      chk("single_hold", 32'(gnt), 32'h08);
    end
    bsw[3] = 8'h3C;
    step(8'h08);
    chk("single_led_upd", 32'(led), 32'h3C);

    // Idle: grant drops next edge, sel/led hold.
    step(8'h00);
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_valid", 32'(led_valid), 32'h0);
    chk("idle_sel", 32'(sel), 32'd3);
    chk("idle_led", 32'(led), 32'h3C);

    // Start a rotation, then reset mid-grant.
    for (int i = 0; i < 8; i++) bsw[i] = 8'(i);
    for (int i = 0; i < 6; i++) step(8'hFF);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_valid", 32'(led_valid), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full rotation from requester 0, four cycles each, 7 wraps to 0.
    for (int k = 0; k < 36; k++) begin
      step(8'hFF);
      chk("rot_sel", 32'(sel), 32'((k / 4) % 8));
      chk("rot_led", 32'(led), 32'((k / 4) % 8));
    end

    // Owner 0 expires; 6 wins, drops after 2 cycles, grant wraps to 0.
    step(8'h41);
    chk("early_sel6", 32'(sel), 32'd6);
    step(8'h41);
    step(8'h01);
    chk("early_wrap_sel", 32'(sel), 32'd0);
    chk("early_wrap_valid", 32'(led_valid), 32'h1);

    // Owner 2 with requester 1 arriving mid-grant: no preemption.
    step(8'h04);
    chk("mid_sel2", 32'(sel), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(8'h06);
      chk("mid_nopreempt", 32'(gnt), 32'h04);
    end
    step(8'h06);
    chk("mid_expire_sel", 32'(sel), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 8; i++) bsw[i] = 8'($urandom);
      step(8'($urandom) & 8'($urandom));
    end

    step(8'h00);
    chk("final_valid", 32'(led_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
